// File: rtl/c5_mult.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the c5 core.
// One operation at a time: 32 shift-add or restoring-divide steps plus a sign fix-up.
module c5_mult #(
  parameter int WIDTH = 32
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic [WIDTH-1:0] I_a_busD,
  input  logic [WIDTH-1:0] I_b_busD,
  input  logic [3:0]       I_mult_funcD,
  input  logic             I_pause_any,
  output logic [WIDTH-1:0] O_c_mult,
  output logic             O_pause
);

  localparam logic [3:0] MULT_NOTHING       = 4'd0;
  localparam logic [3:0] MULT_READ_LO       = 4'd1;
  localparam logic [3:0] MULT_READ_HI       = 4'd2;
  localparam logic [3:0] MULT_WRITE_LO      = 4'd3;
  localparam logic [3:0] MULT_WRITE_HI      = 4'd4;
  localparam logic [3:0] MULT_MULT          = 4'd5;
  localparam logic [3:0] MULT_SIGNED_MULT   = 4'd6;
  localparam logic [3:0] MULT_DIVIDE        = 4'd7;
  localparam logic [3:0] MULT_SIGNED_DIVIDE = 4'd8;

  logic [31:0] r_hi, r_lo, r_bb;
  logic [5:0]  r_count;
  logic        r_mode_div, r_neg_q, r_neg_r;

  logic        w_busy, w_start, w_signed, w_div, w_wr_lo, w_wr_hi;
  logic [31:0] w_a_op, w_b_op;
  logic [32:0] w_msum, w_rsh;
  logic [33:0] w_diff;
  logic [63:0] w_prod_neg;

  assign w_busy = (r_count != 6'd0);

  // Command decode; only accepted when the core is not stalled.
  always_comb begin
    w_start  = 1'b0;
    w_signed = 1'b0;
    w_div    = 1'b0;
    w_wr_lo  = 1'b0;
    w_wr_hi  = 1'b0;
    if (!I_pause_any) begin
      case (I_mult_funcD)
        MULT_WRITE_LO:      w_wr_lo = 1'b1;
        MULT_WRITE_HI:      w_wr_hi = 1'b1;
        MULT_MULT:          w_start = 1'b1;
        MULT_SIGNED_MULT:   begin w_start = 1'b1; w_signed = 1'b1; end
        MULT_DIVIDE:        begin w_start = 1'b1; w_div = 1'b1; end
        MULT_SIGNED_DIVIDE: begin w_start = 1'b1; w_signed = 1'b1; w_div = 1'b1; end
        default:            w_start = 1'b0;
      endcase
    end else begin
      w_start = 1'b0;
    end
  end

  assign w_a_op = (w_signed && I_a_busD[31]) ? (32'd0 - I_a_busD) : I_a_busD;
  assign w_b_op = (w_signed && I_b_busD[31]) ? (32'd0 - I_b_busD) : I_b_busD;

  // Multiply step: lo holds the multiplier and shifts out as the product shifts in.
  assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_bb} : 33'd0);
  // Divide step: hi holds the partial remainder, lo the dividend/quotient.
  assign w_rsh  = {r_hi, r_lo[31]};
  assign w_diff = {1'b0, w_rsh} - {2'b00, r_bb};
  assign w_prod_neg = 64'd0 - {r_hi, r_lo};

  // HI/LO, iteration counter and sign flags.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
      r_bb       <= 32'd0;
      r_count    <= 6'd0;
      r_mode_div <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else if (w_start) begin
      r_count    <= 6'd33;
      r_mode_div <= w_div;
      r_neg_q    <= w_signed & (I_a_busD[31] ^ I_b_busD[31]);
      r_neg_r    <= w_signed & I_a_busD[31];
      r_hi       <= 32'd0;
      r_lo       <= w_a_op;
      r_bb       <= w_b_op;
    end else if (w_wr_lo) begin
      r_lo    <= I_a_busD;
      r_count <= 6'd0;
    end else if (w_wr_hi) begin
      r_hi    <= I_a_busD;
      r_count <= 6'd0;
    end else if (r_count > 6'd1) begin
      r_count <= r_count - 6'd1;
      if (r_mode_div) begin
        if (!w_diff[33]) begin
          r_hi <= w_diff[31:0];
          r_lo <= {r_lo[30:0], 1'b1};
        end else begin
          r_hi <= w_rsh[31:0];
          r_lo <= {r_lo[30:0], 1'b0};
        end
      end else begin
        {r_hi, r_lo} <= {w_msum, r_lo[31:1]};
      end
    end else if (r_count == 6'd1) begin
      r_count <= 6'd0;
      if (r_mode_div) begin
        if (r_neg_q) r_lo <= 32'd0 - r_lo;
        if (r_neg_r) r_hi <= 32'd0 - r_hi;
      end else if (r_neg_q) begin
        {r_hi, r_lo} <= w_prod_neg;
      end
    end
  end

  // Result mux and read-while-busy stall.
  always_comb begin
    O_c_mult = 32'd0;
    O_pause  = 1'b0;
    case (I_mult_funcD)
      MULT_READ_LO: begin O_c_mult = r_lo; O_pause = w_busy; end
      MULT_READ_HI: begin O_c_mult = r_hi; O_pause = w_busy; end
      MULT_NOTHING: O_c_mult = 32'd0;
      default:      O_c_mult = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_c5_mult.sv
// Directed self-checking bench for c5_mult: products, quotients, stalls, aborts, reset.
module tb_c5_mult;

  localparam logic [3:0] F_NOTHING = 4'd0;
  localparam logic [3:0] F_RD_LO   = 4'd1;
  localparam logic [3:0] F_RD_HI   = 4'd2;
  localparam logic [3:0] F_WR_LO   = 4'd3;
  localparam logic [3:0] F_WR_HI   = 4'd4;
  localparam logic [3:0] F_MULT    = 4'd5;
  localparam logic [3:0] F_SMULT   = 4'd6;
  localparam logic [3:0] F_DIV     = 4'd7;
  localparam logic [3:0] F_SDIV    = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_bus, b_bus;
  logic [3:0]  func;
  logic        pause_any;
  logic [31:0] c_mult;
  logic        pause;

  int n_tests = 0;
  int n_fail  = 0;

  c5_mult #(.WIDTH(32)) dut (
    .I_clk(clk), .I_rst(rst), .I_a_busD(a_bus), .I_b_busD(b_bus),
    .I_mult_funcD(func), .I_pause_any(pause_any),
    .O_c_mult(c_mult), .O_pause(pause)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    func = f; a_bus = a; b_bus = b; pause_any = 1'b0;
    tick();
    func = F_NOTHING;
  endtask

  // Hold a read until the unit releases it; returns the number of stalled samples.
  task automatic run_read(input logic [3:0] f, output int pc);
    pc = 0;
    func = f;
    #1;
    while (pause && pc < 100) begin
      pc++;
      tick();
    end
  endtask

  task automatic expect_result(input string tag, input int exp_pc,
                               input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int pc;
    run_read(F_RD_LO, pc);
    check_eq({tag, "_pause"}, 32'(pc), 32'(exp_pc));
    check_eq({tag, "_lo"}, c_mult, exp_lo);
    func = F_RD_HI;
    #1;
    check_eq({tag, "_hi"}, c_mult, exp_hi);
    func = F_NOTHING;
  endtask

  initial begin
    rst = 1'b1; a_bus = 32'd0; b_bus = 32'd0; func = F_NOTHING; pause_any = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    expect_result("reset", 0, 32'h0000_0000, 32'h0000_0000);

    do_op(F_MULT, 32'd3, 32'd5);
    expect_result("mult3x5", 33, 32'h0000_000F, 32'h0000_0000);

    func = F_NOTHING;
    #1;
    check_eq("nothing_out", c_mult, 32'h0000_0000);

    do_op(F_SMULT, 32'hFFFF_FFFE, 32'h0000_0003);
    expect_result("smult", 33, 32'hFFFF_FFFA, 32'hFFFF_FFFF);

    do_op(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_result("mult_max", 33, 32'h0000_0001, 32'hFFFF_FFFE);

    do_op(F_DIV, 32'd100, 32'd7);
    expect_result("div100_7", 33, 32'h0000_000E, 32'h0000_0002);

    do_op(F_SDIV, 32'hFFFF_FFF9, 32'h0000_0002);
    expect_result("sdiv", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    do_op(F_DIV, 32'd9, 32'd0);
    expect_result("div_by0", 33, 32'hFFFF_FFFF, 32'h0000_0009);

    do_op(F_SDIV, 32'hFFFF_FFF9, 32'd0);
    expect_result("sdiv_by0", 33, 32'h0000_0001, 32'hFFFF_FFF9);

    // MULT offered under stall is not accepted
    func = F_MULT; a_bus = 32'd6; b_bus = 32'd7; pause_any = 1'b1;
    tick();
    pause_any = 1'b0; func = F_NOTHING;
    expect_result("stalled_mult", 0, 32'h0000_0001, 32'hFFFF_FFF9);

    // Iteration keeps running while the core is stalled
    do_op(F_MULT, 32'd3, 32'd5);
    pause_any = 1'b1;
    repeat (40) tick();
    pause_any = 1'b0;
    expect_result("iter_in_stall", 0, 32'h0000_000F, 32'h0000_0000);

    // Abort: restart at count=20
    do_op(F_MULT, 32'd2, 32'd2);
    repeat (13) tick();
    do_op(F_MULT, 32'd4, 32'd4);
    expect_result("abort", 33, 32'h0000_0010, 32'h0000_0000);

    // Reset at count=10 with partial product in HI/LO
    do_op(F_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (23) tick();
    func = F_RD_LO;
    #1;
    check_eq("busy_before_rst", 32'(pause), 32'd1);
    func = F_NOTHING; rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_result("mid_reset", 0, 32'h0000_0000, 32'h0000_0000);

    do_op(F_WR_HI, 32'h0000_1234, 32'd0);
    do_op(F_WR_LO, 32'hCAFE_0001, 32'd0);
    expect_result("writes", 0, 32'hCAFE_0001, 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
